// File: rtl/edge_pkg.sv
// Shared constants, beat tag type and RGB565-to-gray helper for the Sobel edge pipeline.
package edge_pkg;

  localparam int GRAD_W = 11;
  localparam logic [GRAD_W-1:0] THRESH_DEF = 11'd100;

  localparam logic [7:0] COEF_R = 8'd77;
  localparam logic [7:0] COEF_G = 8'd150;
  localparam logic [7:0] COEF_B = 8'd29;

  localparam logic [15:0] PIX_WHITE = 16'hFFFF;
  localparam logic [15:0] PIX_BLACK = 16'h0000;

  // Side information that travels with every pixel through the pipeline.
  typedef struct packed {
    logic vld;
    logic sop;
    logic eop;
    logic border;
  } beat_tag_t;

  // Channels are widened by replicating their top bits so full scale maps to 255.
  function automatic logic [7:0] rgb565ToGray(input logic [15:0] pix);
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] acc;
    r8  = {pix[15:11], pix[15:13]};
    g8  = {pix[10:5], pix[10:9]};
    b8  = {pix[4:0], pix[4:2]};
    acc = {8'd0, COEF_R} * {8'd0, r8}
        + {8'd0, COEF_G} * {8'd0, g8}
        + {8'd0, COEF_B} * {8'd0, b8};
    return acc[15:8];
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One-line delay for 8-bit gray pixels: output is the sample written DEPTH valid beats earlier.
module sobel_line_buf #(
  parameter int DEPTH = 640
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  // Read happens before the write at the same address, giving exactly DEPTH beats of delay.
  assign dout_o = mem[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (we_i) begin
      ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/sobel_edge.sv
// RGB565 stream to binary edge map: gray, 3x3 Sobel, threshold, border mask; 4-cycle latency.
module sobel_edge
  import edge_pkg::*;
#(
  parameter int                COL    = 640,
  parameter int                ROW    = 480,
  parameter logic [GRAD_W-1:0] THRESH = THRESH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        din_vld,
  input  logic        din_sop,
  input  logic        din_eop,
  output logic [15:0] dout,
  output logic        dout_vld,
  output logic        dout_sop,
  output logic        dout_eop
);

  localparam int CW = (COL > 1) ? $clog2(COL) : 1;
  localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;

  logic [CW-1:0] colCnt_q, colCnt_d, curCol;
  logic [RW-1:0] rowCnt_q, rowCnt_d, curRow;
  beat_tag_t     tagIn;

  beat_tag_t     tag1_q, tag2_q, tag3_q;
  logic [7:0]    gray_q;
  logic [7:0]    line0Out, line1Out;
  logic [7:0]    win_q [3][3];

  logic signed [GRAD_W-1:0] gx_d, gy_d, gx_q, gy_q;
  logic [GRAD_W-1:0]        absGx, absGy, mag;
  logic [GRAD_W:0]          magSum;
  logic                     edgeHit;

  logic [15:0] dout_q;
  logic        doutVld_q, doutSop_q, doutEop_q;

  // A start-of-frame beat is always position (0,0), whatever the counters hold.
  assign curCol = din_sop ? '0 : colCnt_q;
  assign curRow = din_sop ? '0 : rowCnt_q;

  always_comb begin
    colCnt_d = colCnt_q;
    rowCnt_d = rowCnt_q;
    if (din_vld) begin
      if (curCol == CW'(COL - 1)) begin
        colCnt_d = '0;
        rowCnt_d = (curRow == RW'(ROW - 1)) ? '0 : curRow + 1'b1;
      end else begin
        colCnt_d = curCol + 1'b1;
        rowCnt_d = curRow;
      end
    end
  end

  always_comb begin
    tagIn        = '0;
    tagIn.vld    = din_vld;
    tagIn.sop    = din_vld & din_sop;
    tagIn.eop    = din_vld & din_eop;
    tagIn.border = (curCol < CW'(2)) || (curRow < RW'(2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      colCnt_q <= '0;
      rowCnt_q <= '0;
      tag1_q   <= '0;
      gray_q   <= '0;
    end else begin
      colCnt_q <= colCnt_d;
      rowCnt_q <= rowCnt_d;
      tag1_q   <= tagIn;
      gray_q   <= rgb565ToGray(din);
    end
  end

  sobel_line_buf #(.DEPTH(COL)) u_line0 (
    .clk    (clk),
    .rst    (rst),
    .we_i   (tag1_q.vld),
    .din_i  (gray_q),
    .dout_o (line0Out)
  );

  sobel_line_buf #(.DEPTH(COL)) u_line1 (
    .clk    (clk),
    .rst    (rst),
    .we_i   (tag1_q.vld),
    .din_i  (line0Out),
    .dout_o (line1Out)
  );

  // Row 0 of the window is the oldest line, column 2 the newest pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
      tag2_q <= '0;
    end else begin
      tag2_q <= tag1_q;
      if (tag1_q.vld) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= line1Out;
        win_q[1][2] <= line0Out;
        win_q[2][2] <= gray_q;
      end
    end
  end

  function automatic logic [GRAD_W-1:0] weightedSum(input logic [7:0] a, input logic [7:0] b,
                                                    input logic [7:0] c);
    return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
  endfunction

  // Each weighted sum is at most 1020, so the 11-bit difference never wraps.
  assign gx_d = $signed(weightedSum(win_q[0][2], win_q[1][2], win_q[2][2])
                      - weightedSum(win_q[0][0], win_q[1][0], win_q[2][0]));
  assign gy_d = $signed(weightedSum(win_q[2][0], win_q[2][1], win_q[2][2])
                      - weightedSum(win_q[0][0], win_q[0][1], win_q[0][2]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gx_q   <= '0;
      gy_q   <= '0;
      tag3_q <= '0;
    end else begin
      gx_q   <= gx_d;
      gy_q   <= gy_d;
      tag3_q <= tag2_q;
    end
  end

  assign absGx   = gx_q[GRAD_W-1] ? (~gx_q + 1'b1) : gx_q;
  assign absGy   = gy_q[GRAD_W-1] ? (~gy_q + 1'b1) : gy_q;
  assign magSum  = {1'b0, absGx} + {1'b0, absGy};
  assign mag     = magSum[GRAD_W] ? '1 : magSum[GRAD_W-1:0];
  assign edgeHit = mag > THRESH;

  // Border pixels see stale window or line-buffer data, so they are forced black.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q    <= PIX_BLACK;
      doutVld_q <= 1'b0;
      doutSop_q <= 1'b0;
      doutEop_q <= 1'b0;
    end else begin
      dout_q    <= (tag3_q.vld && !tag3_q.border && edgeHit) ? PIX_WHITE : PIX_BLACK;
      doutVld_q <= tag3_q.vld;
      doutSop_q <= tag3_q.sop;
      doutEop_q <= tag3_q.eop;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = doutVld_q;
  assign dout_sop = doutSop_q;
  assign dout_eop = doutEop_q;

endmodule

// File: tb/tb_sobel_edge.sv
// Bench for sobel_edge: stream-level reference model plus directed frames on an 8x6 image.
module tb_sobel_edge;

  localparam int COL  = 8;
  localparam int ROW  = 6;
  localparam int NPIX = COL * ROW;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        din_vld, din_sop, din_eop;
  logic [15:0] dout;
  logic        dout_vld, dout_sop, dout_eop;

  typedef struct {
    int          due;
    logic [15:0] d;
    logic        s;
    logic        e;
  } exp_t;

  exp_t        expQ[$];
  int          hist[$];
  logic [15:0] outSeq[$];
  logic [15:0] refSeq[$];
  int          sinceSop  = 0;
  int          cyc       = 0;
  int          checks    = 0;
  int          errors    = 0;
  int          edgeCount = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sobel_edge #(.COL(COL), .ROW(ROW), .THRESH(11'd100)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_vld  (din_vld),
    .din_sop  (din_sop),
    .din_eop  (din_eop),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_sop (dout_sop),
    .dout_eop (dout_eop)
  );

  // Gray value straight from the conversion formula, with channel widening done arithmetically.
  function automatic int modelGray(input logic [15:0] p);
    int r5, g6, b5, r8, g8, b8;
    r5 = int'(p[15:11]);
    g6 = int'(p[10:5]);
    b5 = int'(p[4:0]);
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    return (77 * r8 + 150 * g8 + 29 * b8) / 256;
  endfunction

  // Window taken from the gray history: row r lags by (2-r) lines, column c by (2-c) beats.
  function automatic logic [15:0] modelPixel(input int n, input int col, input int row);
    int p[3][3];
    int gx, gy, mag;
    if (col < 2 || row < 2) return 16'h0000;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[r][c] = hist[n - (2 - r) * COL - (2 - c)];
    gx  = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
    gy  = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (mag > 2047) mag = 2047;
    return (mag > 100) ? 16'hFFFF : 16'h0000;
  endfunction

  function automatic logic [15:0] pixFor(input int kind, input int col);
    case (kind)
      0:       return 16'hFFFF;
      1:       return (col >= 4) ? 16'hFFFF : 16'h0000;
      2:       return (col >= 4) ? 16'h0160 : 16'h0000;
      default: return (col >= 4) ? 16'h0161 : 16'h0000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  // Drives one valid beat and records what the DUT must emit 4 cycles later.
  task automatic applyStimulus(input logic [15:0] pix, input logic sop, input logic eop);
    int   col, row;
    exp_t e;
    @(posedge clk);
    #1;
    din     = pix;
    din_vld = 1'b1;
    din_sop = sop;
    din_eop = eop;
    if (sop) sinceSop = 0;
    col = sinceSop % COL;
    row = (sinceSop / COL) % ROW;
    sinceSop++;
    hist.push_back(modelGray(pix));
    e.due = cyc + 4;
    e.d   = modelPixel(hist.size() - 1, col, row);
    e.s   = sop;
    e.e   = eop;
    expQ.push_back(e);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      din     = 16'h0000;
      din_vld = 1'b0;
      din_sop = 1'b0;
      din_eop = 1'b0;
    end
  endtask

  task automatic sendFrame(input int kind, input int gap, input int nBeats);
    for (int i = 0; i < nBeats; i++) begin
      applyStimulus(pixFor(kind, i % COL), i == 0, i == NPIX - 1);
      if (gap > 0) idleCycles(gap);
    end
  endtask

  task automatic waitDrain();
    int guard = 0;
    idleCycles(1);
    while (expQ.size() > 0 && guard < 50) begin
      idleCycles(1);
      guard++;
    end
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expected beats never appeared, required 0", expQ.size());
      expQ.delete();
    end
    idleCycles(2);
  endtask

  task automatic startCapture();
    edgeCount = 0;
    outSeq.delete();
  endtask

  // Single compare process: every cycle the outputs either carry the due beat or are idle.
  initial begin : compare
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (expQ.size() > 0 && expQ[0].due == cyc) begin
        e = expQ.pop_front();
        checkOutput("dout_vld", dout_vld, 1);
        checkOutput("dout", dout, e.d);
        checkOutput("dout_sop", dout_sop, e.s);
        checkOutput("dout_eop", dout_eop, e.e);
        if (dout === 16'hFFFF) edgeCount++;
        outSeq.push_back(dout);
      end else begin
        checkOutput("idle_vld", dout_vld, 0);
        checkOutput("idle_dout", dout, 0);
        checkOutput("idle_sop", dout_sop, 0);
        checkOutput("idle_eop", dout_eop, 0);
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rst     = 1'b1;
    din     = 16'h0000;
    din_vld = 1'b0;
    din_sop = 1'b0;
    din_eop = 1'b0;

    checkOutput("gray_white", modelGray(16'hFFFF), 255);
    checkOutput("gray_25", modelGray(16'h0160), 25);
    checkOutput("gray_26", modelGray(16'h0161), 26);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idleCycles(2);

    $display("[TB] uniform white frame");
    startCapture();
    sendFrame(0, 0, NPIX);
    waitDrain();
    checkOutput("uniform_beats", outSeq.size(), NPIX);
    checkOutput("uniform_edges", edgeCount, 0);

    $display("[TB] vertical step frame");
    startCapture();
    sendFrame(1, 0, NPIX);
    waitDrain();
    checkOutput("step_beats", outSeq.size(), NPIX);
    checkOutput("step_edges", edgeCount, 8);
    refSeq = outSeq;
    checkOutput("step_r2c4", refSeq[2 * COL + 4], 16'hFFFF);
    checkOutput("step_r5c5", refSeq[5 * COL + 5], 16'hFFFF);
    checkOutput("step_r2c3", refSeq[2 * COL + 3], 16'h0000);
    checkOutput("step_r1c4", refSeq[1 * COL + 4], 16'h0000);

    $display("[TB] threshold boundary frames");
    startCapture();
    sendFrame(2, 0, NPIX);
    waitDrain();
    checkOutput("thresh_eq_edges", edgeCount, 0);
    startCapture();
    sendFrame(3, 0, NPIX);
    waitDrain();
    checkOutput("thresh_gt_edges", edgeCount, 8);

    $display("[TB] step frame with input gaps");
    startCapture();
    sendFrame(1, 2, NPIX);
    waitDrain();
    checkOutput("gap_beats", outSeq.size(), NPIX);
    checkOutput("gap_edges", edgeCount, 8);
    if (outSeq.size() == NPIX && refSeq.size() == NPIX) begin
      for (int i = 0; i < NPIX; i++) checkOutput("gap_vs_nogap", outSeq[i], refSeq[i]);
    end

    $display("[TB] reset in the middle of a frame");
    sendFrame(1, 0, 20);
    @(posedge clk);
    #1;
    rst     = 1'b1;
    din_vld = 1'b0;
    din_sop = 1'b0;
    din_eop = 1'b0;
    expQ.delete();
    hist.delete();
    sinceSop = 0;
    idleCycles(3);
    rst = 1'b0;
    idleCycles(2);
    startCapture();
    sendFrame(1, 0, NPIX);
    waitDrain();
    checkOutput("post_reset_edges", edgeCount, 8);

    $display("[TB] start-of-frame reasserted mid-frame");
    startCapture();
    sendFrame(1, 0, 10);
    sendFrame(1, 0, NPIX);
    waitDrain();
    checkOutput("resync_beats", outSeq.size(), 10 + NPIX);
    checkOutput("resync_edges", edgeCount, 8);

    $display("[TB] sop and eop on the same beat");
    applyStimulus(16'hFFFF, 1'b1, 1'b1);
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
